// File: rtl/debounce_pkg.sv
// Shared defaults and counter sizing for the multi-channel button debouncer.
package debounce_pkg;

  localparam int unsigned DEF_N_CH       = 4;
  localparam int unsigned DEF_STABLE_CYC = 2_000_000;
  localparam int unsigned DEF_LONG_CYC   = 100_000_000;

  // One extra bit above clog2 so a counter can hold max_count itself.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounced button: synchronizer, stability filter, long-press timer, edge/pending flags.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy,
  input  logic clr,
  output logic debounced,
  output logic p_edge,
  output logic n_edge,
  output logic any_edge,
  output logic long_press,
  output logic pending
);

  localparam int unsigned SW = cnt_width(STABLE_CYC);
  localparam int unsigned HW = cnt_width(LONG_CYC);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYC - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] LONG_SAT    = HW'(LONG_CYC);

  logic          sync1, sync2;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt;
  logic          toggle;

  assign toggle = (sync2 != debounced) && (stab_cnt == STABLE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stab_cnt   <= '0;
      hold_cnt   <= '0;
      debounced  <= 1'b0;
      p_edge     <= 1'b0;
      n_edge     <= 1'b0;
      any_edge   <= 1'b0;
      long_press <= 1'b0;
      pending    <= 1'b0;
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;

      if ((sync2 == debounced) || toggle) stab_cnt <= '0;
      else                                stab_cnt <= stab_cnt + 1'b1;

      if (toggle) debounced <= ~debounced;
      p_edge   <= toggle & ~debounced;
      n_edge   <= toggle & debounced;
      any_edge <= toggle;

      // Saturating one past the trigger value makes the long-press fire exactly once per hold.
      if (!debounced)                 hold_cnt <= '0;
      else if (hold_cnt != LONG_SAT)  hold_cnt <= hold_cnt + 1'b1;
      long_press <= debounced && (hold_cnt == LONG_LAST);

      pending <= p_edge | (pending & ~clr);
    end
  end

endmodule

// File: rtl/multi_debounce.sv
// N_CH independent button debouncers with edge, long-press and sticky pending flags.
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH       = DEF_N_CH,
  parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] noisy,
  input  logic [N_CH-1:0] clr,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] p_edge,
  output logic [N_CH-1:0] n_edge,
  output logic [N_CH-1:0] _edge,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] pending
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CYC (STABLE_CYC),
      .LONG_CYC   (LONG_CYC)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .noisy      (noisy[g]),
      .clr        (clr[g]),
      .debounced  (debounced[g]),
      .p_edge     (p_edge[g]),
      .n_edge     (n_edge[g]),
      .any_edge   (_edge[g]),
      .long_press (long_press[g]),
      .pending    (pending[g])
    );
  end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter STABLE_CYC, default 2_000_000: consecutive stable samples required to accept a level change (20 ms at 100 MHz), minimum 2.
REQ-003 Parameter LONG_CYC, default 100_000_000: cycles of continuous debounced-high before long-press (1 s at 100 MHz), SHALL exceed STABLE_CYC.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 noisy  input  N_CH  raw asynchronous button levels, one bit per channel.
REQ-007 clr  input  N_CH  per-channel clear of the pending flag, synchronous to clk.
REQ-008 debounced  output  N_CH  filtered registered level per channel.
REQ-009 p_edge  output  N_CH  one-cycle pulse on each debounced 0->1 transition.
REQ-010 n_edge  output  N_CH  one-cycle pulse on each debounced 1->0 transition.
REQ-011 _edge  output  N_CH  p_edge | n_edge per channel.
REQ-012 long_press  output  N_CH  one-cycle pulse when debounced has stayed high for LONG_CYC cycles.
REQ-013 pending  output  N_CH  sticky flag set by p_edge, cleared by clr.

Function
REQ-014 Each noisy bit SHALL pass through a 2-flop synchronizer before any other logic; channels are fully independent.
REQ-015 Stability counter, width clog2(STABLE_CYC)+1: increments each cycle synchronized input != debounced, clears to 0 each cycle they are equal.
REQ-016 When the counter holds STABLE_CYC-1 and inputs still differ, debounced SHALL toggle on that clock edge and the counter clears.
REQ-017 Latency: a clean level change at noisy appears on debounced exactly 2+STABLE_CYC rising edges later.
REQ-018 Any glitch shorter than STABLE_CYC synchronized cycles SHALL leave debounced unchanged and restart the count from 0.
REQ-019 p_edge/n_edge/_edge SHALL be registered and asserted in the same cycle debounced first shows the new level, for exactly one cycle.
REQ-020 Hold counter: saturating, width clog2(LONG_CYC)+1; increments while debounced=1, clears when debounced=0.
REQ-021 long_press SHALL pulse once when the hold counter reaches LONG_CYC-1; no repeat until debounced returns to 0 and rises again.
REQ-022 pending[i] set on p_edge[i]; cleared on clr[i]; simultaneous p_edge and clr SHALL leave pending set.
REQ-023 clr on a channel with pending=0 SHALL have no effect.

Reset
REQ-024 reset_n low SHALL asynchronously force synchronizer flops, counters, debounced, p_edge, n_edge, _edge, long_press and pending to 0.
REQ-025 Reset deassertion while noisy=1 SHALL produce a normal p_edge after 2+STABLE_CYC cycles (no suppression).
REQ-026 Reset asserted mid-count SHALL discard partial counts; no pulses may be emitted during reset.

Structure
REQ-027 Shared package debounce_pkg SHALL hold default STABLE_CYC, LONG_CYC, N_CH and a counter-width helper function.
REQ-028 One sub-module debounce_ch (synchronizer, stability counter, hold counter, edge/pending logic for one bit) SHALL be instantiated N_CH times via generate.

Verification (bench params N_CH=4, STABLE_CYC=8, LONG_CYC=32)
REQ-029 noisy[0] 0->1 held 20 cycles -> debounced[0]=1 and p_edge[0]=_edge[0]=1 for one cycle exactly 10 edges after change, pending[0]=1.
REQ-030 noisy[1] toggled every 3 cycles for 30 cycles then held 0 -> debounced[1], p_edge[1], n_edge[1] stay 0 throughout.
REQ-031 noisy[2] held 1 for 50 cycles -> single long_press[2] pulse 32 cycles after debounced[2] rose; none thereafter; release -> n_edge[2] pulse 10 edges after fall.
REQ-032 clr[0] asserted in same cycle as second p_edge[0] -> pending[0] stays 1; clr[0] next cycle -> pending[0]=0.
REQ-033 reset_n pulled low 5 cycles into a stable count on channel 3 -> all outputs 0 immediately; after release with noisy[3]=1, p_edge[3] after 10 edges.
REQ-034 All four channels switched simultaneously -> four p_edge bits assert in the same cycle, no cross-channel interference.
